// File: rtl/uart_loader.sv
// uart_loader: writer side of the UART program-load path.
// Packs the RX byte stream little-endian into 32-bit words and issues one
// write strobe per word, with consecutive word addresses starting at 0.
// The uart_addr MSB selects the data region and is 0 for instruction memory.
// A session begins on start. It ends when the address space is full, or
// when rx_valid has been idle for TIMEOUT_CYCLES.
// Optional feature macro: UART_LOADER_CHECKSUM_EN. When it is defined, a
// running XOR of all written words must be zero at the end of the session,
// otherwise err is raised.

`ifndef DEFAULT_ROM_DEPTH
`define DEFAULT_ROM_DEPTH 10
`endif

module uart_loader #(
  parameter int ROM_DEPTH      = `DEFAULT_ROM_DEPTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic               busy,
  output logic               uart_write_enable,
  output logic [31:0]        uart_data,
  output logic [ROM_DEPTH:0] uart_addr,
  output logic               done,
  output logic               err
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         byte_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ROM_DEPTH:0] word_addr;
  // Only bytes 0..2 are buffered; byte 3 goes straight into uart_data.
  logic [23:0]        word_q;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [31:0]        csum;
`endif

  // busy follows the state register directly
  assign busy = (state != IDLE);

  // Session FSM: byte assembly, write strobe, address advance, timeout and status
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so that all reads in one cycle see
    // the values from before the edge, independent of statement order.
    if (rst) begin
      state             <= IDLE;
      byte_cnt          <= 2'd0;
      tmo_cnt           <= '0;
      word_addr         <= '0;
      word_q            <= '0;
      uart_write_enable <= 1'b0;
      uart_data         <= '0;
      uart_addr         <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum              <= '0;
`endif
    end else begin
      uart_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          // Bytes that arrive while idle, including one in the start cycle, are dropped.
          if (start) begin
            state     <= RECV;
            done      <= 1'b0;
            err       <= 1'b0;
            word_addr <= '0;
            byte_cnt  <= 2'd0;
            tmo_cnt   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end

        RECV: begin
          if (rx_valid) begin
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_q[7:0]   <= rx_byte;
              2'd1: word_q[15:8]  <= rx_byte;
              2'd2: word_q[23:16] <= rx_byte;
              default: begin
                // The fourth byte completes the word. Raise the strobe in the next cycle.
                state             <= WRITE;
                uart_write_enable <= 1'b1;
                uart_data         <= {rx_byte, word_q};
                uart_addr         <= word_addr;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            // Idle timeout. A partial word is discarded and flagged.
            state    <= IDLE;
            done     <= 1'b1;
            byte_cnt <= 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            err      <= (byte_cnt != 2'd0) || (csum != 32'd0);
`else
            err      <= (byte_cnt != 2'd0);
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        WRITE: begin
          word_addr <= word_addr + 1'b1;
          tmo_cnt   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum      <= csum ^ uart_data;
`endif
          if (&word_addr) begin
            // The last address has been written, so the session ends without waiting for a timeout.
            state    <= IDLE;
            done     <= 1'b1;
            byte_cnt <= 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            err      <= ((csum ^ uart_data) != 32'd0);
`endif
          end else begin
            state <= RECV;
            // A byte that arrives during the strobe cycle is byte 0 of the next word.
            if (rx_valid) begin
              word_q[7:0] <= rx_byte;
              byte_cnt    <= 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed testbench for uart_loader.
// The DUT is built with ROM_DEPTH=2 (8 words) and TIMEOUT_CYCLES=16.
// Expected err values follow UART_LOADER_CHECKSUM_EN when that macro is defined.

`timescale 1ns/1ps

module tb_uart_loader;

  localparam int RD  = 2;
  localparam int TMO = 16;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          busy;
  logic          uart_write_enable;
  logic [31:0]   uart_data;
  logic [RD:0]   uart_addr;
  logic          done;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;

  // Every write strobe seen by the monitor
  int          wr_count = 0;
  logic [RD:0] log_a [64];
  logic [31:0] log_d [64];

  uart_loader #(.ROM_DEPTH(RD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .rx_valid          (rx_valid),
    .rx_byte           (rx_byte),
    .busy              (busy),
    .uart_write_enable (uart_write_enable),
    .uart_data         (uart_data),
    .uart_addr         (uart_addr),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  // Records each write on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (uart_write_enable && wr_count < 64) begin
      log_a[wr_count] = uart_addr;
      log_d[wr_count] = uart_data;
      wr_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends four bytes on consecutive cycles, least significant byte first
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      rx_valid = 1'b1;
      rx_byte  = w[8*k +: 8];
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [RD:0] a, input logic [31:0] d);
    check({tag, "_addr"}, {29'd0, log_a[idx]}, {29'd0, a});
    check({tag, "_data"}, log_d[idx], d);
  endtask

  initial begin
    int base;
    logic [31:0] x;
    logic [31:0] w;

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we",   {31'd0, uart_write_enable}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    check("rst_data", uart_data, 32'd0);
    check("rst_addr", {29'd0, uart_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // A reset in the middle of a session aborts it, and no write follows
    base = wr_count;
    do_start();
    rx_valid = 1'b1; rx_byte = 8'hA1; tick();
    rx_byte = 8'hA2; tick();
    rst = 1'b1; rx_valid = 1'b0; tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    rx_valid = 1'b1; rx_byte = 8'hA3; tick();
    rx_byte = 8'hA4; tick();
    rx_valid = 1'b0; tick(); tick();
    check("abort_nowr", wr_count - base, 0);

    // Test 1: one word, the strobe timing, and the output hold
    base = wr_count;
    do_start();
    check("t1_busy_start", {31'd0, busy}, 32'd1);
    send_word(32'h12345678);
    check("t1_we",   {31'd0, uart_write_enable}, 32'd1);
    check("t1_data", uart_data, 32'h12345678);
    check("t1_addr", {29'd0, uart_addr}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_we_1cyc", {31'd0, uart_write_enable}, 32'd0);
    check("t1_hold",    uart_data, 32'h12345678);
    wait_done("t1_done");
    check("t1_err",   {31'd0, err}, {31'd0, CSUM});
    check("t1_count", wr_count - base, 1);

    // Test 2: two words then a timeout. A start pulse while busy must be ignored.
    base = wr_count;
    do_start();
    check("t2_done_clr", {31'd0, done}, 32'd0);
    send_word(32'h11223344);
    tick();
    do_start();
    send_word(32'hAABBCCDD);
    wait_done("t2_done");
    check("t2_count", wr_count - base, 2);
    check_write("t2_w0", base,     3'd0, 32'h11223344);
    check_write("t2_w1", base + 1, 3'd1, 32'hAABBCCDD);
    x = 32'h11223344 ^ 32'hAABBCCDD;
    check("t2_err",  {31'd0, err}, {31'd0, CSUM && (x != 0)});
    check("t2_busy", {31'd0, busy}, 32'd0);

    // Test 3: a partial word followed by a timeout
    base = wr_count;
    do_start();
    rx_valid = 1'b1; rx_byte = 8'h01; tick();
    rx_byte = 8'h02; tick();
    rx_valid = 1'b0;
    wait_done("t3_done");
    check("t3_err",  {31'd0, err}, 32'd1);
    check("t3_nowr", wr_count - base, 0);
    do_start();
    check("t3_done_clr", {31'd0, done}, 32'd0);
    check("t3_err_clr",  {31'd0, err}, 32'd0);

    // Test 4: a byte that arrives in the WRITE cycle is kept (the stream is continuous)
    base = wr_count;
    send_word(32'h33221100);
    check("t4_we0", {31'd0, uart_write_enable}, 32'd1);
    send_word(32'hDEADBEEF);
    wait_done("t4_done");
    check("t4_count", wr_count - base, 2);
    check_write("t4_w0", base,     3'd0, 32'h33221100);
    check_write("t4_w1", base + 1, 3'd1, 32'hDEADBEEF);

    // Test 5: fill all 8 words back to back. The session ends without a timeout.
    base = wr_count;
    x = 32'd0;
    do_start();
    for (int i = 0; i < 8; i++) begin
      w = 32'h01010101 * (i + 1);
      x = x ^ w;
      send_word(w);
    end
    check("t5_we_last",   {31'd0, uart_write_enable}, 32'd1);
    check("t5_addr_last", {29'd0, uart_addr}, 32'd7);
    tick();
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_err",  {31'd0, err}, {31'd0, CSUM && (x != 0)});
    for (int i = 0; i < 8; i++) begin
      check_write($sformatf("t5_w%0d", i), base + i, 3'(i), 32'h01010101 * (i + 1));
      check($sformatf("t5_msb%0d", i), {31'd0, log_a[base + i][2]}, {31'd0, i >= 4});
    end
    send_word(32'h99999999);
    tick(); tick();
    check("t5_no9th", wr_count - base, 8);

    // Test 6: checksum endings. Both the start and rx_valid are driven in the same idle cycle.
    base = wr_count;
    start = 1'b1; rx_valid = 1'b1; rx_byte = 8'hFF;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    send_word(32'h1); send_word(32'h2); send_word(32'h3);
    wait_done("t6a_done");
    check_write("t6a_w0", base, 3'd0, 32'h1);
    check("t6a_err", {31'd0, err}, 32'd0);
    do_start();
    send_word(32'h1); send_word(32'h2); send_word(32'h4);
    wait_done("t6b_done");
    check("t6b_err", {31'd0, err}, {31'd0, CSUM});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
